// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side PRBS checker for the 31-bit XNOR LFSR stream
// (x^31 + x^28 + 1, new bit = h[30] XNOR h[27]). Self-synchronises, declares
// lock, counts bit errors and detects loss of lock.
// Optional checked-bit counter: define LFSR_CHK_BITCNT_EN. When it is
// undefined, bit_cnt is tied to zero.
module lfsr_checker #(
  parameter int unsigned LOCK_CNT    = 64,
  parameter int unsigned LOSS_THRESH = 8,
  parameter int unsigned ERR_W       = 16,
  parameter int unsigned BIT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chk_en,
  input  logic             chk_valid,
  input  logic             chk_data,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [BIT_W-1:0] bit_cnt
);

  typedef enum logic [1:0] {IDLE, FILL, CHECK, LOCKED} state_t;

  localparam logic [7:0] LOCK_TGT  = 8'(LOCK_CNT);
  localparam logic [7:0] LOSS_TGT  = 8'(LOSS_THRESH);
  localparam logic [4:0] FILL_LAST = 5'd30;

  state_t           state, state_nxt;
  logic [30:0]      hist, hist_nxt;
  logic [4:0]       fill, fill_nxt;
  logic [7:0]       good, good_nxt;
  logic [7:0]       consec, consec_nxt;
  logic             pulse_nxt;
  logic [ERR_W-1:0] err_nxt;
  logic             pred;
  logic             miss;
  logic             all_ones;

  assign pred     = ~(hist[30] ^ hist[27]);
  assign miss     = chk_data ^ pred;
  assign all_ones = &hist;
  assign locked   = (state == LOCKED);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      hist      <= '0;
      fill      <= '0;
      good      <= '0;
      consec    <= '0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      hist      <= hist_nxt;
      fill      <= fill_nxt;
      good      <= good_nxt;
      consec    <= consec_nxt;
      err_pulse <= pulse_nxt;
      err_cnt   <= err_nxt;
    end
  end

  // Next-state, history shift, lock/loss counters and error accounting
  always_comb begin
    state_nxt  = state;
    hist_nxt   = hist;
    fill_nxt   = fill;
    good_nxt   = good;
    consec_nxt = consec;
    pulse_nxt  = 1'b0;
    err_nxt    = err_cnt;

    if (!chk_en) begin
      state_nxt  = IDLE;
      hist_nxt   = '0;
      fill_nxt   = '0;
      good_nxt   = '0;
      consec_nxt = '0;
    end else begin
      case (state)
        // A valid bit on the enabling edge is taken as the first fill bit,
        // so a continuous stream locks on exactly the (31 + LOCK_CNT)th sample.
        IDLE: begin
          state_nxt = FILL;
          if (chk_valid) begin
            hist_nxt = {hist[29:0], chk_data};
            fill_nxt = 5'd1;
          end
        end
        FILL: begin
          if (chk_valid) begin
            hist_nxt = {hist[29:0], chk_data};
            fill_nxt = fill + 5'd1;
            if (fill == FILL_LAST) begin
              state_nxt = CHECK;
              fill_nxt  = '0;
              good_nxt  = '0;
            end
          end
        end
        CHECK: begin
          if (chk_valid) begin
            hist_nxt = {hist[29:0], chk_data};
            if (miss || all_ones) begin
              good_nxt = '0;
            end else if (good + 8'd1 == LOCK_TGT) begin
              state_nxt  = LOCKED;
              good_nxt   = '0;
              consec_nxt = '0;
            end else begin
              good_nxt = good + 8'd1;
            end
          end
        end
        LOCKED: begin
          if (chk_valid) begin
            // Free-running reference: shift in the prediction, not the data
            hist_nxt = {hist[29:0], pred};
            if (miss) begin
              pulse_nxt = 1'b1;
              if (err_cnt != '1) err_nxt = err_cnt + 1'b1;
              if (consec + 8'd1 == LOSS_TGT) begin
                state_nxt  = FILL;
                fill_nxt   = '0;
                consec_nxt = '0;
              end else begin
                consec_nxt = consec + 8'd1;
              end
            end else begin
              consec_nxt = '0;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    if (clr_cnt) err_nxt = '0;
  end

`ifdef LFSR_CHK_BITCNT_EN
  logic [BIT_W-1:0] bits;

  // Saturating count of bits checked while locked; retained through IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bits <= '0;
    end else if (clr_cnt) begin
      bits <= '0;
    end else if (chk_en && chk_valid && state == LOCKED && bits != '1) begin
      bits <= bits + 1'b1;
    end
  end

  assign bit_cnt = bits;
`else
  assign bit_cnt = '0;
`endif

endmodule
